// File: rtl/apb_cmd_queue.sv
// APB slave command queue: DST/OP/DATA registers are pushed as one entry on a
// doorbell write and drained in FIFO order through a valid/ready stream.
// Provides configurable wait states, PSLVERR, sticky overflow and a level IRQ.
module apb_cmd_queue #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [DATA_W-1:0] cmd_dst,
   output logic [DATA_W-1:0] cmd_op,
   output logic [DATA_W-1:0] cmd_data,
   output logic              irq
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [2:0] WS = 3'(WAIT_STATES);

   // SETUP means a setup phase was sampled, so the current cycle is the first
   // access cycle; ACCESS means the transfer is being stretched by wait states.
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state_q, state_d;
   logic [2:0]          wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0]   dst_q, dst_d, op_q, op_d, data_q, data_d;
   logic [1:0]          irq_en_q, irq_en_d;
   logic                ovf_q, ovf_d;
   logic                irq_q;
   logic [3*DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;

   logic              in_xfer, pready, addr_hi_zero, unmapped, err;
   logic              empty, full, push, pop, irq_pend, full_doorbell;
   logic [2:0]        addr_idx;
   logic [DATA_W-1:0] status, rdata;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^PADDR[1:0];

   assign addr_idx      = PADDR[4:2];
   assign addr_hi_zero  = (PADDR[ADDR_W-1:5] == '0);
   assign unmapped      = !addr_hi_zero || (addr_idx == 3'd7);
   assign empty         = (count_q == '0);
   assign full          = (count_q == CW'(DEPTH));
   assign in_xfer       = (state_q != IDLE) && PSEL && PENABLE;
   assign pready        = in_xfer && (wait_cnt_q == WS);
   assign full_doorbell = PWRITE && !unmapped && (addr_idx == 3'd3) && full;
   assign err           = unmapped || (PWRITE && (addr_idx == 3'd4)) || full_doorbell;
   assign push          = pready && PWRITE && !err && (addr_idx == 3'd3);
   assign pop           = !empty && cmd_ready;
   assign irq_pend      = (irq_en_q[0] && ovf_q) || (irq_en_q[1] && !empty);

   // Transfer phase tracking and wait-state counting
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = (in_xfer && !pready) ? wait_cnt_q + 3'd1 : 3'd0;
      case (state_q)
         IDLE:    state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
         SETUP: begin
            if (pready)                  state_d = IDLE;
            else if (PSEL && PENABLE)    state_d = ACCESS;
            else if (PSEL && !PENABLE)   state_d = SETUP;
            else                         state_d = IDLE;
         end
         ACCESS:  state_d = (pready || !(PSEL && PENABLE)) ? IDLE : ACCESS;
         default: state_d = IDLE;
      endcase
   end

   // Register writes take effect only on the completing edge of an error-free write
   always_comb begin
      dst_d    = dst_q;
      op_d     = op_q;
      data_d   = data_q;
      irq_en_d = irq_en_q;
      ovf_d    = ovf_q;
      if (pready && PWRITE && !err) begin
         case (addr_idx)
            3'd0:    dst_d    = PWDATA;
            3'd1:    op_d     = PWDATA;
            3'd2:    data_d   = PWDATA;
            3'd5:    if (PWDATA[0]) ovf_d = 1'b0;
            3'd6:    irq_en_d = PWDATA[1:0];
            default: ;
         endcase
      end
      // A rejected doorbell sets overflow after any clear, so set wins
      if (pready && full_doorbell) ovf_d = 1'b1;
   end

   // Queue pointer and occupancy update; push and pop may share an edge
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // Read data selection, including the packed STATUS word
   always_comb begin
      status       = '0;
      status[15:8] = 8'(count_q);
      status[4]    = irq_pend;
      status[2]    = ovf_q;
      status[1]    = full;
      status[0]    = empty;
      rdata        = '0;
      if (!unmapped) begin
         case (addr_idx)
            3'd0:    rdata = dst_q;
            3'd1:    rdata = op_q;
            3'd2:    rdata = data_q;
            3'd4:    rdata = status;
            3'd6:    rdata[1:0] = irq_en_q;
            default: rdata = '0;
         endcase
      end
   end

   // All state flops, cleared asynchronously so a reset aborts any transfer
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         dst_q      <= '0;
         op_q       <= '0;
         data_q     <= '0;
         irq_en_q   <= '0;
         ovf_q      <= 1'b0;
         irq_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         dst_q      <= dst_d;
         op_q       <= op_d;
         data_q     <= data_d;
         irq_en_q   <= irq_en_d;
         ovf_q      <= ovf_d;
         irq_q      <= irq_pend;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         if (push) mem_q[wr_ptr_q] <= {dst_q, op_q, data_q};
      end
   end

   assign PREADY    = pready;
   assign PSLVERR   = pready && err;
   assign PRDATA    = (pready && !PWRITE) ? rdata : '0;
   assign cmd_valid = !empty;
   assign {cmd_dst, cmd_op, cmd_data} = mem_q[rd_ptr_q];
   assign irq       = irq_q;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Bench for apb_cmd_queue: a queue-level reference model plus directed APB traffic.
module tb_apb_cmd_queue;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int WS    = 3;

   logic          PCLK = 1'b0;
   logic          PRESETn, PSEL, PENABLE, PWRITE;
   logic [7:0]    PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic          PREADY, PSLVERR, cmd_valid, cmd_ready, irq;
   logic [DW-1:0] cmd_dst, cmd_op, cmd_data;

   apb_cmd_queue #(.ADDR_W(8), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst(cmd_dst), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      logic [DW-1:0] dst;
      logic [DW-1:0] op;
      logic [DW-1:0] data;
   } cmd_t;

   // reference model state
   cmd_t       mq[$];
   logic [31:0] m_dst, m_op, m_data;
   logic [1:0]  m_ien;
   logic        m_ovf, m_irq;
   logic        fire, fire_wr;
   logic [7:0]  fire_addr;
   logic [31:0] fire_wdata;
   logic        cmp_en = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic m_reset();
      mq.delete();
      m_dst = '0; m_op = '0; m_data = '0; m_ien = '0; m_ovf = 1'b0; m_irq = 1'b0;
   endtask

   function automatic logic m_pend();
      return (m_ien[0] && m_ovf) || (m_ien[1] && (mq.size() != 0));
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s       = '0;
      s[15:8] = 8'(mq.size());
      s[4]    = m_pend();
      s[2]    = m_ovf;
      s[1]    = (mq.size() == DEPTH);
      s[0]    = (mq.size() == 0);
      return s;
   endfunction

   function automatic logic m_err(input logic [7:0] a, input logic wr);
      int idx;
      idx = int'(a) / 4;
      if (idx >= 7) return 1'b1;
      if (wr && idx == 4) return 1'b1;
      if (wr && idx == 3 && mq.size() == DEPTH) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [7:0] a);
      case (int'(a) / 4)
         0:       return m_dst;
         1:       return m_op;
         2:       return m_data;
         4:       return m_status();
         6:       return {30'd0, m_ien};
         default: return 32'd0;
      endcase
   endfunction

   // model update on every active edge while out of reset
   initial begin
      logic do_pop, do_push, was_full;
      cmd_t e;
      forever begin
         @(posedge PCLK);
         if (PRESETn) begin
            do_pop   = (mq.size() != 0) && cmd_ready;
            was_full = (mq.size() == DEPTH);
            do_push  = 1'b0;
            e        = {m_dst, m_op, m_data};
            m_irq    = m_pend();
            if (fire && fire_wr && (int'(fire_addr) / 4) < 7) begin
               case (int'(fire_addr) / 4)
                  0: m_dst  = fire_wdata;
                  1: m_op   = fire_wdata;
                  2: m_data = fire_wdata;
                  3: if (was_full) m_ovf = 1'b1; else do_push = 1'b1;
                  5: if (fire_wdata[0]) m_ovf = 1'b0;
                  6: m_ien  = fire_wdata[1:0];
                  default: ;
               endcase
            end
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
         end
      end
   end

   // stream and interrupt comparison on every cycle
   initial begin
      forever begin
         @(negedge PCLK);
         if (cmp_en) begin
            chk("cmd_valid", 32'(cmd_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
               chk("cmd_dst", cmd_dst, mq[0].dst);
               chk("cmd_op", cmd_op, mq[0].op);
               chk("cmd_data", cmd_data, mq[0].data);
            end
            chk("irq", 32'(irq), 32'(m_irq));
         end
      end
   end

   task automatic apb(input logic [7:0] a, input logic wr, input logic [31:0] wd,
                      input logic rdy_at_fire, output logic [31:0] rd, output logic er);
      logic [31:0] exp_rd;
      logic        exp_er;
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
      #1 chk("pready_setup", 32'(PREADY), 32'd0);
      @(negedge PCLK);
      PENABLE = 1'b1;
      for (int c = 0; c <= WS; c++) begin
         #1;
         if (c < WS) begin
            chk("pready_wait", 32'(PREADY), 32'd0);
         end else begin
            exp_er = m_err(a, wr);
            exp_rd = (wr || exp_er) ? 32'd0 : m_rdata(a);
            chk("pready_done", 32'(PREADY), 32'd1);
            chk("pslverr", 32'(PSLVERR), 32'(exp_er));
            if (!wr) chk("prdata", PRDATA, exp_rd);
            rd = PRDATA; er = PSLVERR;
            fire = 1'b1; fire_wr = wr; fire_addr = a; fire_wdata = wd;
            if (rdy_at_fire) cmd_ready = 1'b1;
         end
         @(negedge PCLK);
      end
      fire = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      if (rdy_at_fire) cmd_ready = 1'b0;
      $display("apb %s addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0d",
               wr ? "WR" : "RD", a, wd, rd, er);
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic        er;
      apb(a, 1'b1, d, 1'b0, rd, er);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; cmd_ready = 1'b0;
      fire = 1'b0; fire_wr = 1'b0; fire_addr = '0; fire_wdata = '0;
      m_reset();

      // reset state
      repeat (5) @(negedge PCLK);
      #1;
      chk("rst_pready", 32'(PREADY), 32'd0);
      chk("rst_pslverr", 32'(PSLVERR), 32'd0);
      chk("rst_prdata", PRDATA, 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd_dst", cmd_dst, 32'd0);
      chk("rst_cmd_op", cmd_op, 32'd0);
      chk("rst_cmd_data", cmd_data, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      cmp_en  = 1'b1;
      apb(8'h10, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t1_status", rd, 32'h0000_0001);

      // single command through the queue
      wr_reg(8'h00, 32'd6);
      wr_reg(8'h04, 32'd20102025);
      wr_reg(8'h08, 32'd75799072);
      wr_reg(8'h0C, 32'd65828469);
      chk("t2_valid", 32'(cmd_valid), 32'd1);
      chk("t2_dst", cmd_dst, 32'd6);
      chk("t2_op", cmd_op, 32'd20102025);
      chk("t2_data", cmd_data, 32'd75799072);
      apb(8'h10, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t2_status", rd, 32'h0000_0100);
      cmd_ready = 1'b1;
      @(negedge PCLK);
      cmd_ready = 1'b0;
      chk("t2_popped", 32'(cmd_valid), 32'd0);

      // overflow, clear, ordered drain
      for (int i = 0; i <= DEPTH; i++) begin
         wr_reg(8'h00, 32'(100 + i));
         wr_reg(8'h04, 32'(200 + i));
         wr_reg(8'h08, 32'(300 + i));
         apb(8'h0C, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, rd, er);
         if (i == DEPTH) chk("t3_ovf_err", 32'(er), 32'd1);
      end
      apb(8'h10, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t3_status", rd, 32'h0000_0406);
      wr_reg(8'h14, 32'd1);
      apb(8'h10, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t3_cleared", rd, 32'h0000_0402);
      for (int k = 0; k < DEPTH; k++) begin
         chk("t3_order", cmd_dst, 32'(100 + k));
         cmd_ready = 1'b1;
         @(negedge PCLK);
      end
      cmd_ready = 1'b0;
      chk("t3_drained", 32'(cmd_valid), 32'd0);

      // unmapped and illegal accesses
      apb(8'h1C, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t5_rd_err", 32'(er), 32'd1);
      chk("t5_rd_data", rd, 32'd0);
      apb(8'h1C, 1'b1, 32'hFFFF_FFFF, 1'b0, rd, er);
      chk("t5_wr_err", 32'(er), 32'd1);
      apb(8'h20, 1'b1, 32'h1234_5678, 1'b0, rd, er);
      apb(8'h10, 1'b1, 32'hFFFF_FFFF, 1'b0, rd, er);
      chk("t5_status_wr_err", 32'(er), 32'd1);
      apb(8'h00, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t5_dst_kept", rd, 32'd104);
      apb(8'h0D, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t5_doorbell_rd_err", 32'(er), 32'd0);

      // interrupt enables
      wr_reg(8'h18, 32'd3);
      apb(8'h18, 1'b0, 32'd0, 1'b0, rd, er);
      chk("irq_en_rd", rd, 32'd3);
      wr_reg(8'h0C, 32'd0);
      @(negedge PCLK);
      chk("irq_nonempty", 32'(irq), 32'd1);

      // full queue: doorbell on the same edge as a pop is rejected
      for (int i = 1; i < DEPTH; i++) wr_reg(8'h0C, 32'd0);
      apb(8'h0C, 1'b1, 32'd0, 1'b1, rd, er);
      chk("t6_push_rejected", 32'(er), 32'd1);
      apb(8'h10, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t6_status", rd, 32'h0000_0314);

      // reset in the middle of an access phase
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h10;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #2 PRESETn = 1'b0;
      m_reset();
      #1;
      chk("t6_rst_pready", 32'(PREADY), 32'd0);
      chk("t6_rst_valid", 32'(cmd_valid), 32'd0);
      chk("t6_rst_irq", 32'(irq), 32'd0);
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      apb(8'h10, 1'b0, 32'd0, 1'b0, rd, er);
      chk("t6_status_after_rst", rd, 32'h0000_0001);

      repeat (2) @(negedge PCLK);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
